// File: rtl/turn_signal_input_cond_pkg.sv
// ============================================================================
// turn_signal_pkg : default constants and shared types for the turn-signal
//                   input conditioner.
// Rev 1.0
// ============================================================================
`default_nettype none

package turn_signal_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int TICK_DIV_DEF        = 2500000;

  localparam int DEB_CNT_W_DEF  = $clog2(DEBOUNCE_CYCLES_DEF + 1);
  localparam int TICK_CNT_W_DEF = $clog2(TICK_DIV_DEF);

  // The three levels that define the light-sequence mode; a change in any
  // of them restarts the step period.
  typedef struct packed {
    logic hazard;
    logic turn_en;
    logic right_sel;
  } mode_t;

endpackage

`default_nettype wire

// File: rtl/turn_signal_input_cond_if.sv
// ============================================================================
// turn_signal_input_cond_if : raw board inputs and conditioned outputs of the
//                             turn-signal input conditioner.
// Rev 1.0
// ============================================================================
`default_nettype none

interface turn_signal_input_cond_if;

  logic key_lr_n;
  logic sw_hazard;
  logic sw_turn_en;
  logic hazard;
  logic turn_en;
  logic lr_press;
  logic right_sel;
  logic step_tick;

  // master = board/stimulus side, slave = conditioner
  modport master (
    output key_lr_n, sw_hazard, sw_turn_en,
    input  hazard, turn_en, lr_press, right_sel, step_tick
  );

  modport slave (
    input  key_lr_n, sw_hazard, sw_turn_en,
    output hazard, turn_en, lr_press, right_sel, step_tick
  );

endinterface

`default_nettype wire

// File: rtl/turn_signal_input_cond_debounce_filter.sv
// ============================================================================
// debounce_filter : synchronizer, consecutive-mismatch counter and stable
//                   level register with registered fall/rise strobes.
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_filter
  import turn_signal_pkg::*;
#(
  parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o,
  output logic change_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   fall_q, fall_d;
  logic                   rise_q, rise_d;
  logic                   synced;
  logic                   mismatch;
  logic                   flip;

  assign synced = sync_q[SYNC_STAGES-1];

  // cnt never passes CNT_LAST: reaching it with a mismatch flips and clears.
  always_comb begin
    mismatch = (synced != stable_q);
    flip     = mismatch && (cnt_q == CNT_LAST);
    cnt_d    = '0;
    if (mismatch && !flip) begin
      cnt_d = cnt_q + 1'b1;
    end
    stable_d = stable_q ^ flip;
    fall_d   = flip &  stable_q;
    rise_d   = flip & ~stable_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= {SYNC_STAGES{RESET_VAL}};
      cnt_q    <= '0;
      stable_q <= RESET_VAL;
      fall_q   <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      fall_q   <= fall_d;
      rise_q   <= rise_d;
    end
  end

  assign level_o  = stable_q;
  assign fall_o   = fall_q;
  assign rise_o   = rise_q;
  assign change_o = flip;

endmodule

`default_nettype wire

// File: rtl/turn_signal_input_cond.sv
// ============================================================================
// turn_signal_input_cond : conditions the L/R key and hazard/turn switches
//                          and generates step_tick for the light FSM.
// Build option: DEBOUNCE_SWITCHES_EN also debounces the two switches.
// Rev 1.0
// ============================================================================
`default_nettype none

module turn_signal_input_cond
  import turn_signal_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TICK_DIV        = TICK_DIV_DEF
) (
  input  logic                    ADC_CLK_10,
  input  logic                    reset,
  turn_signal_input_cond_if.slave bus
);

  localparam int                TCNT_W    = $clog2(TICK_DIV);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);

  logic              key_level, key_fall, key_rise, key_change;
  logic              haz_lvl, ten_lvl, haz_chg, ten_chg;
  logic              right_sel_q, right_sel_d;
  logic              step_tick_q, step_tick_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              tick_wrap, restart;
  mode_t             mode_chg;
  logic              unused_key;

  debounce_filter #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (1'b1)
  ) u_key_filter (
    .clk_i    (ADC_CLK_10),
    .rst_i    (reset),
    .raw_i    (bus.key_lr_n),
    .level_o  (key_level),
    .fall_o   (key_fall),
    .rise_o   (key_rise),
    .change_o (key_change)
  );

  assign unused_key = ^{key_level, key_rise, key_change};

`ifdef DEBOUNCE_SWITCHES_EN
  logic haz_fall, haz_rise, ten_fall, ten_rise;
  logic unused_sw;

  debounce_filter #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (1'b0)
  ) u_haz_filter (
    .clk_i    (ADC_CLK_10),
    .rst_i    (reset),
    .raw_i    (bus.sw_hazard),
    .level_o  (haz_lvl),
    .fall_o   (haz_fall),
    .rise_o   (haz_rise),
    .change_o (haz_chg)
  );

  debounce_filter #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (1'b0)
  ) u_ten_filter (
    .clk_i    (ADC_CLK_10),
    .rst_i    (reset),
    .raw_i    (bus.sw_turn_en),
    .level_o  (ten_lvl),
    .fall_o   (ten_fall),
    .rise_o   (ten_rise),
    .change_o (ten_chg)
  );

  assign unused_sw = ^{haz_fall, haz_rise, ten_fall, ten_rise};
`else
  logic [SYNC_STAGES-1:0] haz_sync_q, ten_sync_q;

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      haz_sync_q <= '0;
      ten_sync_q <= '0;
    end else begin
      haz_sync_q <= {haz_sync_q[SYNC_STAGES-2:0], bus.sw_hazard};
      ten_sync_q <= {ten_sync_q[SYNC_STAGES-2:0], bus.sw_turn_en};
    end
  end

  // A level changes at the next edge when the last two stages disagree.
  assign haz_lvl = haz_sync_q[SYNC_STAGES-1];
  assign ten_lvl = ten_sync_q[SYNC_STAGES-1];
  assign haz_chg = haz_sync_q[SYNC_STAGES-1] ^ haz_sync_q[SYNC_STAGES-2];
  assign ten_chg = ten_sync_q[SYNC_STAGES-1] ^ ten_sync_q[SYNC_STAGES-2];
`endif

  // right_sel flips on the edge where lr_press is high, so that edge is
  // also a mode change; a restart takes precedence over a pending wrap.
  always_comb begin
    mode_chg           = '0;
    mode_chg.hazard    = haz_chg;
    mode_chg.turn_en   = ten_chg;
    mode_chg.right_sel = key_fall;
    restart            = |mode_chg;
    tick_wrap          = (tcnt_q == TCNT_LAST);
    right_sel_d        = right_sel_q ^ key_fall;
    step_tick_d        = tick_wrap && !restart;
    tcnt_d             = (restart || tick_wrap) ? '0 : tcnt_q + 1'b1;
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      right_sel_q <= 1'b0;
      step_tick_q <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      right_sel_q <= right_sel_d;
      step_tick_q <= step_tick_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign bus.hazard    = haz_lvl;
  assign bus.turn_en   = ten_lvl;
  assign bus.lr_press  = key_fall;
  assign bus.right_sel = right_sel_q;
  assign bus.step_tick = step_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_turn_signal_input_cond.sv
// ============================================================================
// tb_turn_signal_input_cond : directed and random stimulus against a
//                             history-window reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_turn_signal_input_cond;

  localparam int SYNC = 2;
  localparam int DC   = 4;
  localparam int TD   = 5;
  localparam int HMAX = 4096;
`ifdef DEBOUNCE_SWITCHES_EN
  localparam int SW_LAT = SYNC + DC;
`else
  localparam int SW_LAT = SYNC;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  turn_signal_input_cond_if bus ();

  turn_signal_input_cond #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DC),
    .TICK_DIV        (TD)
  ) dut (
    .ADC_CLK_10 (clk),
    .reset      (reset),
    .bus        (bus)
  );

  // Reference model: raw samples per post-reset edge, outputs derived from
  // the rules (window of DC synced samples, anchor-based tick period).
  logic hist [3][HMAX];
  int   n, anchor;
  logic m_key, m_haz, m_ten, m_right, m_press, m_tick;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic synced(int w, int j, logic rv);
    if (j - SYNC >= 1) return hist[w][j-SYNC];
    return rv;
  endfunction

  function automatic logic window_flip(int w, int e, logic state, logic rv);
    if (e < DC) return 1'b0;
    for (int i = 0; i < DC; i++) begin
      if (synced(w, e - i, rv) == state) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    n = 0; anchor = 0;
    m_key = 1'b1; m_haz = 1'b0; m_ten = 1'b0;
    m_right = 1'b0; m_press = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_edge(input logic k, input logic h, input logic t);
    logic old_h, old_t, old_r, new_press, chg;
    if (n < HMAX - 2) n++;
    hist[0][n] = k; hist[1][n] = h; hist[2][n] = t;
    old_h = m_haz; old_t = m_ten; old_r = m_right;
    m_right   = m_right ^ m_press;
    new_press = 1'b0;
    if (window_flip(0, n, m_key, 1'b1)) begin
      new_press = m_key;
      m_key     = ~m_key;
    end
    m_press = new_press;
`ifdef DEBOUNCE_SWITCHES_EN
    if (window_flip(1, n, m_haz, 1'b0)) m_haz = ~m_haz;
    if (window_flip(2, n, m_ten, 1'b0)) m_ten = ~m_ten;
`else
    m_haz = synced(1, n + 1, 1'b0);
    m_ten = synced(2, n + 1, 1'b0);
`endif
    chg    = (m_haz != old_h) || (m_ten != old_t) || (m_right != old_r);
    m_tick = ((n - anchor) == TD) && !chg;
    if (chg || (n - anchor) == TD) anchor = n;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic k, input logic h, input logic t);
    bus.key_lr_n   = k;
    bus.sw_hazard  = h;
    bus.sw_turn_en = t;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(k, h, t);
    #1;
    check_bit("hazard",    bus.hazard,    m_haz);
    check_bit("turn_en",   bus.turn_en,   m_ten);
    check_bit("lr_press",  bus.lr_press,  m_press);
    check_bit("right_sel", bus.right_sel, m_right);
    check_bit("step_tick", bus.step_tick, m_tick);
  endtask

  initial begin
    int first_ev, second_ev, ev_a, ev_b;
    logic rk, rh, rt;
    int len;

    model_reset();
    bus.key_lr_n = 1'b1; bus.sw_hazard = 1'b0; bus.sw_turn_en = 1'b0;

    // 1: reset state and free-running tick
    reset = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    first_ev = -1; second_ev = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus.step_tick && first_ev < 0)                  first_ev  = i;
      else if (bus.step_tick && second_ev < 0)            second_ev = i;
    end
    check_int("first_tick_edge",  first_ev,  5);
    check_int("second_tick_edge", second_ev, 10);

    // 2: clean press and release
    ev_a = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.lr_press && ev_a < 0) ev_a = i;
    end
    check_int("press_latency", ev_a, SYNC + DC);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    check_bit("right_sel_after_release", bus.right_sel, 1'b1);

    // 3: bounce shorter than the filter
    step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    check_bit("right_sel_after_bounce", bus.right_sel, 1'b1);

    // 4: hazard rise restarts the period, then a change landing on a wrap
    ev_a = -1; ev_b = -1;
    for (int i = 1; i <= 14; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (bus.hazard && ev_a < 0) ev_a = i;
      if (bus.step_tick && ev_a > 0 && ev_b < 0) ev_b = i;
    end
    check_int("hazard_latency",       ev_a,        SW_LAT);
    check_int("tick_after_hazard",    ev_b - ev_a, TD);
    for (int i = 0; i < 2 * TD && (n + 2) != (anchor + TD); i++) step(1'b1, 1'b1, 1'b0);
    repeat (12) step(1'b1, 1'b0, 1'b0);

    // 5: reset while the key mismatch counter is mid-count
    repeat (SYNC + DC - 1) step(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    ev_a = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.lr_press && ev_a < 0) ev_a = i;
    end
    check_int("press_after_reset", ev_a, SYNC + DC);
    repeat (8) step(1'b1, 1'b0, 1'b0);

    // 6: turn-enable glitch, then a steady hold
    step(1'b1, 1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    ev_a = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (bus.turn_en && ev_a < 0) ev_a = i;
    end
    check_int("turn_en_latency", ev_a, SW_LAT);

    // random segments of held input combinations
    for (int seg = 0; seg < 80; seg++) begin
      rk  = 1'($urandom_range(0, 1));
      rh  = 1'($urandom_range(0, 1));
      rt  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      repeat (len) step(rk, rh, rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
